mem_bus_arbiter: RTL

//  Shares one SRAM-like memory bus (req/addr_ok/data_ok) between the IF-stage

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between the fetch port and the load/store port.
// Only one transaction is in flight at a time. A starvation counter guarantees that fetch makes progress.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_r;
  logic             owner_data_r;
  logic             cancel_r;
  logic [CNT_W-1:0] cnt_r;
  logic             grant_data_s;
  logic             cancel_now_s;
  logic             resp_s;

  // Winner selection: data normally wins a tie unless fetch has starved long enough
  always_comb begin
    grant_data_s = 1'b0;
    if (inst_req && data_req) begin
      grant_data_s = (cnt_r != LIMIT);
    end else begin
      grant_data_s = data_req;
    end
  end

  // Cancel only applies to a fetch; it is folded in on the completing cycle too
  always_comb begin
    cancel_now_s = cancel_r | (inst_cancel & ~owner_data_r);
    resp_s       = 1'b0;
    case (state_r)
      ADDR:    resp_s = bus_addr_ok & bus_data_ok;
      DATA:    resp_s = bus_data_ok;
      default: resp_s = 1'b0;
    endcase
  end

  // Transaction FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      owner_data_r <= 1'b0;
      cancel_r     <= 1'b0;
      cnt_r        <= '0;
      bus_req      <= 1'b0;
      bus_wr       <= 1'b0;
      bus_size     <= 2'd0;
      bus_addr     <= 32'd0;
      bus_wdata    <= 32'd0;
      inst_rdata   <= 32'd0;
      inst_data_ok <= 1'b0;
      data_rdata   <= 32'd0;
      data_data_ok <= 1'b0;
      busy         <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state_r)
        IDLE: begin
          if (inst_req || data_req) begin
            state_r      <= ADDR;
            busy         <= 1'b1;
            bus_req      <= 1'b1;
            owner_data_r <= grant_data_s;
            if (grant_data_s) begin
              bus_wr    <= data_wr;
              bus_size  <= data_size;
              bus_addr  <= data_addr;
              bus_wdata <= data_wdata;
              if (!inst_req) begin
                cnt_r <= '0;
              end else if (cnt_r != LIMIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end else begin
              bus_wr    <= 1'b0;
              bus_size  <= 2'd2;
              bus_addr  <= inst_addr;
              bus_wdata <= 32'd0;
              cnt_r     <= '0;
            end
          end
        end
        ADDR: begin
          cancel_r <= cancel_now_s;
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state_r <= bus_data_ok ? RESP : DATA;
          end
        end
        DATA: begin
          cancel_r <= cancel_now_s;
          if (bus_data_ok) begin
            state_r <= RESP;
          end
        end
        RESP: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          cancel_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          bus_req  <= 1'b0;
          cancel_r <= 1'b0;
        end
      endcase
      if (resp_s) begin
        if (owner_data_r) begin
          data_rdata   <= bus_rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= bus_rdata;
          inst_data_ok <= ~cancel_now_s;
        end
      end
    end
  end

endmodule
